// File: rtl/sl_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sl_word_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO for 34-bit tagged
//             words (tag [33:32], payload [31:0]). Words pass through
//             unchanged and the tag is never interpreted. One instance
//             carries host commands toward the transceiver bridge; another
//             carries responses back to the host.
//
//  Ports    : clk               system clock, rising edge
//             rst               asynchronous active-high reset
//             write_data        word to push
//             write_inc         push request
//             write_full        FIFO holds 2**ADDR_WIDTH words
//             write_almost_full level >= AFULL_LEVEL
//             read_data         head word, forced to 0 while empty
//             read_inc          pop request
//             read_empty        FIFO holds no words
//             level             current word count, 0..2**ADDR_WIDTH
//
//  Optional : define SL_FIFO_ERR_FLAGS_EN to add the sticky error flags
//             overflow / underflow and their synchronous clear err_clear.
//
//  Revision : 1.0  initial release
// ============================================================================
module sl_word_fifo #(
    parameter int DATA_WIDTH  = 34,
    parameter int ADDR_WIDTH  = 3,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SL_FIFO_ERR_FLAGS_EN
    input  logic                  err_clear,
    output logic                  overflow,
    output logic                  underflow,
`endif
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_inc,
    output logic                  write_full,
    output logic                  write_almost_full,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_inc,
    output logic                  read_empty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int                  c_depth       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_afull_level = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    // Pointers carry one extra wrap bit so that full and empty can be
    // told apart when the low address bits match.
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_level_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_afull_nxt;

    // ------------------------------------------------------------------
    // Accept logic: qualify requests with the registered flags, so a push
    // while full and a pop while empty are dropped. At full, a
    // simultaneous push/pop therefore pops only; at empty it pushes only.
    // ------------------------------------------------------------------
    assign w_push = write_inc & ~r_full;
    assign w_pop  = read_inc  & ~r_empty;

    assign w_wr_ptr_nxt = r_wr_ptr + (ADDR_WIDTH + 1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_WIDTH + 1)'(w_pop);

    // Flags and level are derived from the next pointer values and then
    // registered, so they change on the same edge as the pointers.
    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    assign w_full_nxt  = (w_wr_ptr_nxt[ADDR_WIDTH] != w_rd_ptr_nxt[ADDR_WIDTH]) &&
                         (w_wr_ptr_nxt[ADDR_WIDTH-1:0] == w_rd_ptr_nxt[ADDR_WIDTH-1:0]);
    // Modular difference of the wrap-extended pointers is exactly the
    // word count 0..depth.
    assign w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_afull_nxt = (w_level_nxt >= c_afull_level);

    // ------------------------------------------------------------------
    // Pointer and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
            r_afull  <= w_afull_nxt;
        end
    end

    // Memory is deliberately left out of reset; stale words are never
    // visible because read_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head word is an asynchronous read of the current read address, so
    // the following word appears as soon as the read pointer advances.
    assign read_data         = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign read_empty        = r_empty;
    assign write_full        = r_full;
    assign write_almost_full = r_afull;
    assign level             = r_level;

`ifdef SL_FIFO_ERR_FLAGS_EN
    // ------------------------------------------------------------------
    // Sticky error flags. The set term is OR-ed after the clear term so a
    // new error on the same edge as err_clear keeps the flag asserted.
    // ------------------------------------------------------------------
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (write_inc & r_full)  | (r_overflow  & ~err_clear);
            r_underflow <= (read_inc  & r_empty) | (r_underflow & ~err_clear);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sl_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sl_word_fifo
//  Purpose  : Self-checking bench for sl_word_fifo. A queue-based reference
//             model tracks the FIFO contents and derives every expected
//             output from the word count and the head of the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sl_word_fifo;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [33:0] write_data = '0;
    logic        write_inc  = 1'b0;
    logic        read_inc   = 1'b0;
    logic        write_full;
    logic        write_almost_full;
    logic [33:0] read_data;
    logic        read_empty;
    logic [3:0]  level;
`ifdef SL_FIFO_ERR_FLAGS_EN
    logic        err_clear = 1'b0;
    logic        overflow;
    logic        underflow;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO is just an ordered list of words.
    logic [33:0] m_q [$];

    sl_word_fifo dut (
        .clk               (clk),
        .rst               (rst),
`ifdef SL_FIFO_ERR_FLAGS_EN
        .err_clear         (err_clear),
        .overflow          (overflow),
        .underflow         (underflow),
`endif
        .write_data        (write_data),
        .write_inc         (write_inc),
        .write_full        (write_full),
        .write_almost_full (write_almost_full),
        .read_data         (read_data),
        .read_inc          (read_inc),
        .read_empty        (read_empty),
        .level             (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("level",      64'(level),             64'(n));
        check("read_empty", 64'(read_empty),        64'(n == 0));
        check("write_full", 64'(write_full),        64'(n == DEPTH));
        check("afull",      64'(write_almost_full), 64'(n >= AFULL));
        check("read_data",  64'(read_data),         (n > 0) ? 64'(m_q[0]) : 64'd0);
`ifdef SL_FIFO_ERR_FLAGS_EN
        check("overflow",   64'(overflow),          64'(m_ovf));
        check("underflow",  64'(underflow),         64'(m_unf));
`endif
    endtask

    // One clock: apply inputs, let the edge happen, update the model, check.
    task automatic cycle(input logic wi, input logic [33:0] wd, input logic ri);
        bit do_push;
        bit do_pop;
        bit was_full;
        bit was_empty;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        do_push   = wi && !was_full;
        do_pop    = ri && !was_empty;
        write_inc  = wi;
        write_data = wd;
        read_inc   = ri;
        @(posedge clk);
        #1;
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(wd);
`ifdef SL_FIFO_ERR_FLAGS_EN
        m_ovf = (wi && was_full)  || (m_ovf && !err_clear);
        m_unf = (ri && was_empty) || (m_unf && !err_clear);
`endif
        write_inc = 1'b0;
        read_inc  = 1'b0;
        check_all();
    endtask

    task automatic drain();
        while (m_q.size() > 0) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [33:0] w;

        // ---- reset state ------------------------------------------------
        #12;
        check("rst_level", 64'(level),      64'd0);
        check("rst_empty", 64'(read_empty), 64'd1);
        check("rst_full",  64'(write_full), 64'd0);
        check("rst_afull", 64'(write_almost_full), 64'd0);
        check("rst_rdata", 64'(read_data),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- 1: single word round trip ------------------------------------
        cycle(1'b1, 34'h0_00000057, 1'b0);
        check("t1_rdata", 64'(read_data), 64'h0_00000057);
        cycle(1'b0, '0, 1'b1);
        check("t1_empty", 64'(read_empty), 64'd1);

        // ---- 2: fill to full, overflow attempt, drain in order ------------
        for (int i = 0; i < DEPTH; i++) begin
            w = {2'(i), 32'(100 + i)};
            cycle(1'b1, w, 1'b0);
            if (i == 5) check("t2_afull6", 64'(write_almost_full), 64'd1);
        end
        check("t2_full8", 64'(write_full), 64'd1);
        cycle(1'b1, 34'h3_DEADBEEF, 1'b0);
        check("t2_level9", 64'(level), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_order", 64'(read_data[31:0]), 64'(100 + i));
            cycle(1'b0, '0, 1'b1);
        end
        check("t2_empty", 64'(read_empty), 64'd1);

        // ---- 3: simultaneous push/pop while full --------------------------
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, {2'(i), 32'(100 + i)}, 1'b0);
        cycle(1'b1, 34'h1_00000005, 1'b1);
        check("t3_level", 64'(level),      64'd7);
        check("t3_full",  64'(write_full), 64'd0);
        check("t3_head",  64'(read_data[31:0]), 64'd101);
        drain();

        // ---- 4: simultaneous push/pop while empty -------------------------
        cycle(1'b1, 34'h2_0000004C, 1'b1);
        check("t4_level", 64'(level),     64'd1);
        check("t4_rdata", 64'(read_data), 64'h2_0000004C);
        drain();

        // ---- 5: steady state across pointer wrap, then async reset --------
        for (int i = 0; i < 3; i++) cycle(1'b1, {2'($urandom), 32'($urandom)}, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, {2'($urandom), 32'($urandom)}, 1'b1);
        cycle(1'b1, {2'($urandom), 32'($urandom)}, 1'b0);
        check("t5_level4", 64'(level), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_level", 64'(level),      64'd0);
        check("t5_async_empty", 64'(read_empty), 64'd1);
        check("t5_async_rdata", 64'(read_data),  64'd0);
        m_q.delete();
`ifdef SL_FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 34'h1_0000AAAA, 1'b0);
        cycle(1'b1, 34'h1_0000BBBB, 1'b0);
        drain();

`ifdef SL_FIFO_ERR_FLAGS_EN
        // ---- 6: sticky error flags ----------------------------------------
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 34'(i), 1'b0);
        cycle(1'b1, 34'h3_DEADBEEF, 1'b0);
        check("t6_ovf_set", 64'(overflow), 64'd1);
        cycle(1'b0, '0, 1'b0);
        check("t6_ovf_hold", 64'(overflow), 64'd1);
        drain();
        cycle(1'b0, '0, 1'b1);
        check("t6_unf_set", 64'(underflow), 64'd1);
        err_clear = 1'b1;
        cycle(1'b0, '0, 1'b0);
        err_clear = 1'b0;
        check("t6_ovf_clr", 64'(overflow),  64'd0);
        check("t6_unf_clr", 64'(underflow), 64'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 34'(i), 1'b0);
        err_clear = 1'b1;
        cycle(1'b1, 34'h1_00000001, 1'b0);
        err_clear = 1'b0;
        check("t6_set_wins", 64'(overflow), 64'd1);
        drain();
`endif

        // ---- randomized traffic ------------------------------------------
        for (int i = 0; i < 400; i++) begin
            logic wi;
            logic ri;
            wi = ($urandom_range(0, 99) < 55);
            ri = ($urandom_range(0, 99) < 45 + ((i / 100) % 2) * 20);
`ifdef SL_FIFO_ERR_FLAGS_EN
            err_clear = ($urandom_range(0, 15) == 0);
`endif
            cycle(wi, {2'($urandom), 32'($urandom)}, ri);
        end
`ifdef SL_FIFO_ERR_FLAGS_EN
        err_clear = 1'b0;
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
